// File: rtl/ring_nic.sv
// ring_nic: network interface between a processor core and the PE port of one
// ring router. The core sees a 4-entry register window:
//   addr 00  input channel buffer  (read returns the packet and frees the slot)
//   addr 01  input channel status  (bit 0 = in_full)
//   addr 10  output channel buffer (write queues a packet for injection)
//   addr 11  output channel status (bit 0 = out_full)
// Each channel holds at most one packet. Injection waits for router ready and
// for the router polarity to match the packet's VC bit (bit 63).
//
// Optional feature: define RING_NIC_STATS_EN to add 16-bit tx/rx packet
// counters. Both status words then report tx_cnt in 63:48 and rx_cnt in 47:32.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   addr, din, en,   processor register access (wrEn=1 write, 0 read)
//   wrEn, dout       dout is registered, valid the cycle after a read
//   net_polarity     router polarity
//   net_so/net_ro    send / ready handshake into the router PE input
//   net_do           packet to the router
//   net_si/net_ri    send / ready handshake from the router PE output
//   net_di           packet from the router
module ring_nic #(
   parameter int unsigned DATA_W = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        addr,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   input  logic              en,
   input  logic              wrEn,
   input  logic              net_polarity,
   output logic              net_so,
   input  logic              net_ro,
   output logic [DATA_W-1:0] net_do,
   input  logic              net_si,
   output logic              net_ri,
   input  logic [DATA_W-1:0] net_di
);

   localparam int unsigned VC_BIT = DATA_W - 1;
`ifdef RING_NIC_STATS_EN
   localparam int unsigned CNT_W  = 16;
`endif

   localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
   localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
   localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
   localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } chan_state_t;

   chan_state_t       out_state;
   chan_state_t       in_state;
   logic [DATA_W-1:0] out_buf;
   logic [DATA_W-1:0] in_buf;

   logic              out_full;
   logic              in_full;
   logic              rd_en;
   logic              wr_out;
   logic              rd_in;
   logic              capture;
   logic [DATA_W-1:0] in_status;
   logic [DATA_W-1:0] out_status;

`ifdef RING_NIC_STATS_EN
   logic [CNT_W-1:0]  tx_cnt;
   logic [CNT_W-1:0]  rx_cnt;
`endif

   assign out_full = (out_state == FULL);
   assign in_full  = (in_state == FULL);

   // Access decode
   assign rd_en  = en & ~wrEn;
   assign wr_out = en & wrEn & (addr == ADDR_OUT_BUF);
   assign rd_in  = rd_en & (addr == ADDR_IN_BUF);

   // Router handshakes; both are held low while reset is asserted
   assign net_so  = out_full & net_ro & (net_polarity == out_buf[VC_BIT]) & ~reset;
   assign net_ri  = ~in_full & ~reset;
   assign capture = net_si & net_ri;
   assign net_do  = out_buf;

   // Status words: full flag in bit 0, optional counters in the top half
   always_comb begin
      in_status     = '0;
      out_status    = '0;
      in_status[0]  = in_full;
      out_status[0] = out_full;
`ifdef RING_NIC_STATS_EN
      in_status[DATA_W-1 -: CNT_W]          = tx_cnt;
      in_status[DATA_W-1-CNT_W -: CNT_W]    = rx_cnt;
      out_status[DATA_W-1 -: CNT_W]         = tx_cnt;
      out_status[DATA_W-1-CNT_W -: CNT_W]   = rx_cnt;
`endif
   end

   // Channel FSMs, buffers and registered read data
   always_ff @(posedge clk) begin
      if (reset) begin
         out_state <= EMPTY;
         in_state  <= EMPTY;
         out_buf   <= '0;
         in_buf    <= '0;
         dout      <= '0;
`ifdef RING_NIC_STATS_EN
         tx_cnt    <= '0;
         rx_cnt    <= '0;
`endif
      end else begin
         // Output channel: a write into a FULL slot (even one being sent
         // this same cycle) is dropped.
         case (out_state)
            EMPTY: begin
               if (wr_out) begin
                  out_buf   <= din;
                  out_state <= FULL;
               end
            end
            FULL: begin
               if (net_so) begin
                  out_buf   <= '0;
                  out_state <= EMPTY;
               end
            end
            default: out_state <= EMPTY;
         endcase

         // Input channel: capture only when ready; a read frees the slot but
         // keeps the last packet visible as stale data.
         case (in_state)
            EMPTY: begin
               if (capture) begin
                  in_buf   <= net_di;
                  in_state <= FULL;
               end
            end
            FULL: begin
               if (rd_in) begin
                  in_state <= EMPTY;
               end
            end
            default: in_state <= EMPTY;
         endcase

         if (rd_en) begin
            case (addr)
               ADDR_IN_BUF:   dout <= in_buf;
               ADDR_IN_STAT:  dout <= in_status;
               ADDR_OUT_BUF:  dout <= out_buf;
               ADDR_OUT_STAT: dout <= out_status;
               default:       dout <= '0;
            endcase
         end

`ifdef RING_NIC_STATS_EN
         if (net_so) begin
            tx_cnt <= tx_cnt + CNT_W'(1);
         end
         if (capture) begin
            rx_cnt <= rx_cnt + CNT_W'(1);
         end
`endif
      end
   end

endmodule
